// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Purpose  : Scans a 4x4 active-low membrane keypad one column at a time,
//            synchronizes the row returns, and debounces whole-matrix scans
//            into a stable key code for the downstream music player.
// Ports    : clk          - system clock, rising edge
//            reset        - asynchronous active-low reset
//            row_in[3:0]  - keypad rows, active-low, asynchronous to clk
//            col_out[3:0] - column drive, one-hot-low
//            keypad_value - last accepted key code (row*4 + col), held after
//                           release
//            key_valid    - high while a debounced key is held
//            key_pressed  - one-cycle strobe on each newly accepted key code
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] keypad_value,
    output logic       key_valid,
    output logic       key_pressed
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] COUNT_MAX  = CW'(DEBOUNCE);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HELD = 1'b1;

    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [DW-1:0] dwell;
    logic [1:0]    col;
    logic [15:0]   samples;
    logic [0:0]    state;
    logic [CW-1:0] match_cnt;
    logic [3:0]    candidate;
    logic          count_none;

    logic          sample_now;
    logic          scan_done;
    logic [15:0]   scan_map;
    logic [4:0]    n_low;
    logic [3:0]    scan_code;
    logic          is_none;
    logic          is_single;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] single_cnt;
    logic [CW-1:0] none_cnt;

    assign sample_now = (dwell == DWELL_LAST);
    assign scan_done  = sample_now && (col == 2'd3);
    assign col_out    = ~(4'b0001 << col);

    // Column 3 is evaluated on the same cycle it is sampled, so its bits come
    // straight from the synchronizer instead of the sample register.
    always_comb begin
        scan_map  = samples;
        n_low     = 5'd0;
        scan_code = 4'd0;
        for (int r = 0; r < 4; r++) begin
            scan_map[r*4 + 3] = ~row_sync[r];
        end
        for (int i = 0; i < 16; i++) begin
            if (scan_map[i]) begin
                n_low     = n_low + 5'd1;
                scan_code = 4'(i);
            end
        end
    end

    assign is_none   = (n_low == 5'd0);
    assign is_single = (n_low == 5'd1);

    // Saturating increment; a run that started with a different class or code
    // restarts at one.
    assign cnt_inc    = (match_cnt == COUNT_MAX) ? match_cnt : match_cnt + COUNT_ONE;
    assign single_cnt = (!count_none && scan_code == candidate) ? cnt_inc : COUNT_ONE;
    assign none_cnt   = count_none ? cnt_inc : COUNT_ONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dwell   <= '0;
            col     <= 2'd0;
            samples <= 16'h0000;
        end else begin
            if (sample_now) begin
                dwell <= '0;
                col   <= col + 2'd1;
                for (int r = 0; r < 4; r++) begin
                    samples[{2'(r), col}] <= ~row_sync[r];
                end
            end else begin
                dwell <= dwell + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            match_cnt    <= '0;
            candidate    <= 4'd0;
            count_none   <= 1'b0;
            keypad_value <= 4'd0;
            key_valid    <= 1'b0;
            key_pressed  <= 1'b0;
        end else begin
            key_pressed <= 1'b0;
            if (scan_done) begin
                if (!is_single && !is_none) begin
                    match_cnt <= '0;
                end else if (state == ST_IDLE) begin
                    if (is_none) begin
                        match_cnt <= '0;
                    end else begin
                        candidate  <= scan_code;
                        count_none <= 1'b0;
                        if (single_cnt == COUNT_MAX) begin
                            state        <= ST_HELD;
                            keypad_value <= scan_code;
                            key_valid    <= 1'b1;
                            key_pressed  <= 1'b1;
                            match_cnt    <= '0;
                        end else begin
                            match_cnt <= single_cnt;
                        end
                    end
                end else begin
                    if (is_none) begin
                        count_none <= 1'b1;
                        if (none_cnt == COUNT_MAX) begin
                            state     <= ST_IDLE;
                            key_valid <= 1'b0;
                            match_cnt <= '0;
                        end else begin
                            match_cnt <= none_cnt;
                        end
                    end else if (scan_code == keypad_value) begin
                        match_cnt <= '0;
                    end else begin
                        candidate  <= scan_code;
                        count_none <= 1'b0;
                        if (single_cnt == COUNT_MAX) begin
                            keypad_value <= scan_code;
                            key_pressed  <= 1'b1;
                            match_cnt    <= '0;
                        end else begin
                            match_cnt <= single_cnt;
                        end
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Purpose  : Self-checking bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE=2).
//            A physical keypad model drives the rows from the column drive;
//            a scan-level reference model predicts the debounced outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 2;
    localparam int SCAN_LEN = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  keypad_value;
    logic        key_valid;
    logic        key_pressed;
    logic [15:0] keys;

    int          compared = 0;
    int          fails    = 0;

    // Reference model state: last scan result (-1 none, -2 multi, else code),
    // length of the current run of identical results, and expected outputs.
    int          m_prev;
    int          m_streak;
    logic        m_valid;
    logic [3:0]  m_value;

    keypad_scanner #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .row_in       (row_in),
        .col_out      (col_out),
        .keypad_value (keypad_value),
        .key_valid    (key_valid),
        .key_pressed  (key_pressed)
    );

    always #5 clk = ~clk;

    // A pressed key shorts its row to its column; driven column is low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4 + c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    function automatic int classify(input logic [15:0] k);
        int n   = 0;
        int idx = 0;
        for (int i = 0; i < 16; i++) begin
            if (k[i]) begin
                n++;
                idx = i;
            end
        end
        if (n == 0) return -1;
        if (n > 1)  return -2;
        return idx;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev   = -3;
        m_streak = 0;
        m_valid  = 1'b0;
        m_value  = 4'd0;
    endtask

    // Called at a negedge that starts a scan; returns at the negedge right
    // after that scan's deciding edge.
    task automatic run_scan(input logic [15:0] k);
        int         res;
        int         stray;
        logic       exp_pulse;
        logic [3:0] exp_col;
        keys  = k;
        stray = 0;
        for (int i = 0; i < SCAN_LEN; i++) begin
            @(negedge clk);
            if (i < SCAN_LEN - 1) begin
                exp_col = ~(4'b0001 << ((i + 1) / SCAN_DIV));
                check("col_out", col_out, exp_col);
                if (key_pressed) stray++;
            end
        end
        res = classify(k);
        if (res == m_prev) begin
            m_streak++;
        end else begin
            m_prev   = res;
            m_streak = 1;
        end
        exp_pulse = 1'b0;
        if (m_streak == DEBOUNCE) begin
            if (res >= 0 && (!m_valid || 4'(res) != m_value)) begin
                m_valid   = 1'b1;
                m_value   = 4'(res);
                exp_pulse = 1'b1;
            end else if (res == -1 && m_valid) begin
                m_valid = 1'b0;
            end
        end
        check("stray_pulse", 16'(stray), 16'd0);
        check("key_pressed", key_pressed, exp_pulse);
        check("keypad_value", keypad_value, m_value);
        check("key_valid", key_valid, m_valid);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] k;
        int          sel;
        int          reps;
        int          a;
        int          b;
        int          pool [5];

        keys  = 16'h0000;
        reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_col_out", col_out, 4'b1110);
        check("rst_keypad_value", keypad_value, 4'd0);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_key_pressed", key_pressed, 1'b0);
        reset = 1'b1;

        // Walk with no key, then clean press of key 9 (row 2, col 1).
        run_scan(16'h0000);
        run_scan(16'h0200);
        run_scan(16'h0200);
        run_scan(16'h0200);
        // Release after two empty scans.
        run_scan(16'h0000);
        run_scan(16'h0000);
        // Bounce rejection from IDLE.
        run_scan(16'h0200);
        run_scan(16'h0000);
        run_scan(16'h0200);
        run_scan(16'h0000);
        // Keys 0 and 5 together are ignored.
        run_scan(16'h0021);
        run_scan(16'h0021);
        run_scan(16'h0021);
        // Press 9, single empty scan, 9 again stays valid.
        run_scan(16'h0200);
        run_scan(16'h0200);
        run_scan(16'h0000);
        run_scan(16'h0200);
        // Change to key 14 (row 3, col 2), then back to 9.
        run_scan(16'h4000);
        run_scan(16'h4000);
        run_scan(16'h0200);
        run_scan(16'h0200);

        // Asynchronous reset while HELD(9), between clock edges.
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_keypad_value", keypad_value, 4'd0);
        check("midrst_key_valid", key_valid, 1'b0);
        check("midrst_col_out", col_out, 4'b1110);
        check("midrst_key_pressed", key_pressed, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        run_scan(16'h0200);
        run_scan(16'h0200);
        run_scan(16'h0000);
        run_scan(16'h0000);

        // Randomized runs of patterns, biased so runs reach the debounce count.
        pool[0] = 9; pool[1] = 14; pool[2] = 0; pool[3] = 5; pool[4] = 15;
        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel <= 2) begin
                k = 16'h0000;
            end else if (sel <= 7) begin
                a = (sel == 7) ? int'($urandom_range(0, 15)) : pool[$urandom_range(0, 4)];
                k = 16'h0001 << a;
            end else begin
                a = int'($urandom_range(0, 15));
                b = (a + 1 + int'($urandom_range(0, 14))) % 16;
                k = (16'h0001 << a) | (16'h0001 << b);
            end
            reps = int'($urandom_range(1, 3));
            for (int j = 0; j < reps; j++) run_scan(k);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans the 4x4 membrane keypad matrix, synchronizes and debounces the row returns, and produces the stable 4-bit `keypad_value` consumed directly by `music_player`.
- Sits upstream of `music_player`, in the same clock domain.
- `keypad_value` holds the last debounced key after release, which gives `music_player` a level-style input.
- Also provides `key_valid` (a key is currently held) and a one-cycle `key_pressed` strobe for new presses.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven. Minimum legal value is 4.
- DEBOUNCE, 4: consecutive identical full-matrix scans required to accept a press, change or release. Minimum legal value is 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted). Outputs return to reset values immediately; release is sampled on clk.
- row_in  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
- col_out  output  4  column drive, active-low, one-hot-low.
- keypad_value  output  4  debounced key code, row*4 + col.
- key_valid  output  1  high while a debounced key is held.
- key_pressed  output  1  one-cycle pulse on each accepted new key code.

Behaviour:
- Reset values:
  - col_out = 4'b1110 (column 0 driven).
  - keypad_value = 0, key_valid = 0, key_pressed = 0.
  - Dwell counter, column index, match counter, candidate code and FSM all cleared; FSM = IDLE.
- Synchronizer: row_in passes through a 2-flop synchronizer before any use.
- Column scan:
  - A dwell counter counts 0..SCAN_DIV-1 per column; the column index steps 0->1->2->3->0.
  - col_out drives bit [col] low and all other bits high.
  - The synchronized rows are sampled when dwell == SCAN_DIV-1. This gives at least 2 cycles of settling after the column change.
  - A full scan is 4*SCAN_DIV cycles. scan_done is internal and asserts on the sample cycle of column 3.
- Scan evaluation at scan_done, over the 16 accumulated samples:
  - Exactly one key low -> scan_code = row*4 + col, class SINGLE.
  - No key low -> class NONE.
  - Two or more keys low -> class MULTI. MULTI clears the match counter and otherwise changes nothing.
- Debounce FSM (match counter is saturating, 0..DEBOUNCE):
  - IDLE:
    - SINGLE: if code == candidate, increment; otherwise load candidate and set count = 1.
    - When count reaches DEBOUNCE -> HELD. keypad_value <= candidate, key_valid <= 1, key_pressed pulses.
    - NONE clears the count.
  - HELD:
    - SINGLE equal to keypad_value clears the count.
    - SINGLE with a different code counts as in IDLE. At DEBOUNCE: keypad_value <= new code, key_pressed pulses, state stays HELD.
    - NONE counts consecutive scans. At DEBOUNCE -> IDLE, key_valid <= 0, keypad_value holds, no pulse.
    - Any class interruption restarts the count.
- Latency: output updates are registered and become visible on the cycle after the deciding scan_done. key_pressed is high for exactly that one cycle.
- DEBOUNCE = 1: a single scan decides.
- Counters wrap only as specified above; the match counter never overflows.
- Reset mid-scan or mid-HELD: immediate return to reset values. Scanning restarts at column 0 on the first cycle after release.

Test Plan (SCAN_DIV=4, DEBOUNCE=2; scan period 16 cycles):
- Reset and walk: hold reset=0 -> col_out=1110, keypad_value=0, key_valid=0, key_pressed=0. Release -> col_out steps 1110, 1101, 1011, 0111 every 4 cycles, then repeats.
- Clean press: model row 2 low whenever col_out[1]=0, held steady -> after the second full scan, keypad_value=9, key_valid=1, and key_pressed is high for exactly one cycle on the cycle after scan_done.
- Bounce rejection: key 9 present for one scan, absent the next, present one scan -> no change to outputs and no pulse.
- Release: from HELD(9), remove the key -> after 2 empty scans key_valid=0, keypad_value stays 9, no pulse. A single empty scan followed by 9 again -> key_valid remains 1.
- Multi-key and change:
  - From IDLE, press keys 0 and 5 together for 3 scans -> outputs unchanged.
  - From HELD(9), switch to key 14 (row 3, col 2) for 2 scans -> keypad_value=14, key_valid stays 1, one key_pressed pulse.
- Reset mid-operation: assert reset during HELD(9) between clock edges -> keypad_value=0, key_valid=0, col_out=1110 immediately, before the next edge. After release, a held key re-debounces with the same latency as a clean press.
